axi4_lite_lbs_bridge: RTL and testbench

Parametrised AXI4-Lite slave to local-bus (lbs) bridge feeding up to NUM_SLV register-bank slaves. It is the next generation of the single-slave, 32-bit, edge-detected cpu_we/cpu_rd bridge and adds:
- region decode with DECERR responses
- byte enables
- configurable read latency
- fair read/write arbitration

It sits between the processor interconnect and the per-function register banks (conv, capture, LED).

---
 rtl/axi4_lite_lbs_pkg.sv | 24 ++
 rtl/axi4_lite_lbs_bridge_if.sv | 33 +++
 rtl/lbs_addr_decode.sv | 37 +++
 rtl/axi4_lite_lbs_bridge.sv | 138 +++++++++++++
 tb/tb_axi4_lite_lbs_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_lbs_pkg.sv
// Shared constants for the AXI4-Lite to local-bus bridge: response codes,
// FSM state encoding and a constant-evaluable clog2.
package axi4_lite_lbs_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_RWAIT = 3'd4;
    localparam logic [2:0] ST_RRESP = 3'd5;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_lite_lbs_bridge_if.sv
// AXI4-Lite channel bundle between the interconnect (master) and the bridge (slave).
interface axi4_lite_lbs_bridge_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/lbs_addr_decode.sv
// Combinational region decode: picks the slave index from the address and flags
// addresses above the last slave region as misses.
module lbs_addr_decode import axi4_lite_lbs_pkg::*; #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SLV_AW  = 12,
    parameter int unsigned NUM_SLV = 4,
    localparam int unsigned IDX_W  = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] onehot
);
    localparam int unsigned SEL_W   = clog2(NUM_SLV);
    localparam int unsigned TOP_LSB = SLV_AW + SEL_W;

    // Offset bits inside a region do not take part in the decode.
    logic [SLV_AW-1:0] unused_offset;
    assign unused_offset = addr[SLV_AW-1:0];

    if (SEL_W > 0) begin : g_idx
        assign idx = addr[SLV_AW +: SEL_W];
    end else begin : g_idx_single
        assign idx = '0;
    end

    if (TOP_LSB < ADDR_W) begin : g_hit
        assign hit = (addr[ADDR_W-1:TOP_LSB] == '0);
    end else begin : g_hit_full
        assign hit = 1'b1;
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/axi4_lite_lbs_bridge.sv
// AXI4-Lite slave to local-bus bridge: one transaction in flight, fair read/write
// arbitration, region decode with DECERR, byte enables and configurable read latency.
module axi4_lite_lbs_bridge import axi4_lite_lbs_pkg::*; #(
    parameter int          U_DLY   = 1,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SLV_AW  = 12,
    parameter int unsigned RD_LAT  = 1,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned LBS_AW = SLV_AW - clog2(STRB_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    axi4_lite_lbs_bridge_if.slave     axi,
    output logic [NUM_SLV-1:0]        lbs_sel,
    output logic [LBS_AW-1:0]         lbs_addr,
    output logic [DATA_W-1:0]         lbs_din,
    output logic [STRB_W-1:0]         lbs_be,
    output logic                      lbs_we,
    output logic                      lbs_re,
    input  logic [NUM_SLV*DATA_W-1:0] lbs_dout
);
    localparam int unsigned IDX_W    = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;
    localparam int unsigned OFF_W    = clog2(STRB_W);
    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);
    // Assignment delay applies to simulation only; the registers below do not use it.
    localparam int          unused_dly = U_DLY;

    logic [2:0]         state_q, state_d;
    logic               last_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [2:0]         cnt_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         bresp_q, rresp_q;

    logic               idle, wr_req, rd_req, grant_wr, grant_rd;
    logic [ADDR_W-1:0]  dec_addr;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [NUM_SLV-1:0] dec_onehot;

    assign idle   = (state_q == ST_IDLE);
    assign wr_req = axi.awvalid && axi.wvalid;
    assign rd_req = axi.arvalid;
    // On contention the channel not served last wins.
    assign grant_wr = idle && wr_req && (!rd_req || !last_wr_q);
    assign grant_rd = idle && rd_req && (!wr_req || last_wr_q);

    assign axi.awready = grant_wr;
    assign axi.wready  = grant_wr;
    assign axi.arready = grant_rd;
    assign axi.bvalid  = (state_q == ST_WRESP);
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (state_q == ST_RRESP);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign lbs_we      = (state_q == ST_WR);
    assign lbs_re      = (state_q == ST_RD);

    assign dec_addr = grant_wr ? axi.awaddr : axi.araddr;

    lbs_addr_decode #(
        .ADDR_W  (ADDR_W),
        .SLV_AW  (SLV_AW),
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .addr   (dec_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_d = dec_hit ? ST_WR : ST_WRESP;
                end else if (grant_rd) begin
                    state_d = dec_hit ? ST_RD : ST_RRESP;
                end
            end
            ST_WR:    state_d = ST_WRESP;
            ST_WRESP: if (axi.bready) state_d = ST_IDLE;
            ST_RD:    state_d = ST_RWAIT;
            ST_RWAIT: if (cnt_q == LAT_LAST) state_d = ST_RRESP;
            ST_RRESP: if (axi.rready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            lbs_sel   <= '0;
            lbs_addr  <= '0;
            lbs_din   <= '0;
            lbs_be    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_wr || grant_rd) begin
                last_wr_q <= grant_wr;
                idx_q     <= dec_idx;
                lbs_sel   <= dec_hit ? dec_onehot : '0;
                lbs_addr  <= dec_hit ? dec_addr[SLV_AW-1:OFF_W] : '0;
            end
            if (grant_wr) begin
                lbs_din <= axi.wdata;
                lbs_be  <= axi.wstrb;
                bresp_q <= dec_hit ? OKAY : DECERR;
            end
            if (grant_rd && !dec_hit) begin
                rdata_q <= '0;
                rresp_q <= DECERR;
            end
            if (state_q == ST_RD) begin
                cnt_q <= '0;
            end else if (state_q == ST_RWAIT) begin
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == LAT_LAST) begin
                    rdata_q <= lbs_dout[idx_q*DATA_W +: DATA_W];
                    rresp_q <= OKAY;
                end
            end
            if (!idle && state_d == ST_IDLE) begin
                lbs_sel  <= '0;
                lbs_addr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_lbs_bridge.sv
// Self-checking bench: register-bank slave model behind the bridge, a transaction-level
// reference memory, a directed vector table, corner-case sequences and random traffic.
module tb_axi4_lite_lbs_bridge;
    localparam int RD_LAT = 3;
    localparam logic [1:0] R_OKAY   = 2'b00;
    localparam logic [1:0] R_DECERR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_lbs_bridge_if #(.ADDR_W(16), .DATA_W(32)) axi ();

    logic [3:0]   lbs_sel;
    logic [9:0]   lbs_addr;
    logic [31:0]  lbs_din;
    logic [3:0]   lbs_be;
    logic         lbs_we;
    logic         lbs_re;
    logic [127:0] lbs_dout;

    axi4_lite_lbs_bridge #(
        .U_DLY   (1),
        .ADDR_W  (16),
        .DATA_W  (32),
        .NUM_SLV (4),
        .SLV_AW  (12),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .axi      (axi),
        .lbs_sel  (lbs_sel),
        .lbs_addr (lbs_addr),
        .lbs_din  (lbs_din),
        .lbs_be   (lbs_be),
        .lbs_we   (lbs_we),
        .lbs_re   (lbs_re),
        .lbs_dout (lbs_dout)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int w);
        return 32'h5000_0000 | 32'(k << 16) | 32'(w);
    endfunction

    // Slave register banks with a read pipeline that only shows data RD_LAT cycles after lbs_re.
    logic [31:0] slv_mem [4][1024];
    logic [31:0] rd_word_q;
    int          rd_age;
    int          rd_slot;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_age    <= 0;
            rd_slot   <= 0;
            rd_word_q <= '0;
            for (int k = 0; k < 4; k++)
                for (int w = 0; w < 1024; w++) slv_mem[k][w] <= init_word(k, w);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lbs_sel[k]) begin
                    if (lbs_we) slv_mem[k][lbs_addr] <= merge(slv_mem[k][lbs_addr], lbs_din, lbs_be);
                    if (lbs_re) begin
                        rd_slot   <= k;
                        rd_word_q <= slv_mem[k][lbs_addr];
                    end
                end
            end
            if (lbs_re) rd_age <= 1;
            else if (rd_age != 0 && rd_age < 15) rd_age <= rd_age + 1;
        end
    end

    always_comb begin
        lbs_dout = {4{32'hBAD0_BAD0}};
        if (rd_age == RD_LAT) lbs_dout[rd_slot*32 +: 32] = rd_word_q;
    end

    // Transaction-level reference: word memory per slave region.
    logic [31:0] ref_mem [4][1024];

    task automatic do_reset();
        rst = 1'b1;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 0; axi.rready = 0;
        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 1024; w++) ref_mem[k][w] = init_word(k, w);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int stall, output logic [1:0] resp);
        logic hit, ok;
        logic [1:0] idx, exp_resp;
        logic [9:0] word;
        logic [3:0] exp_sel;
        int n;
        hit      = (a[15:14] == 2'b00);
        idx      = a[13:12];
        word     = a[11:2];
        exp_sel  = hit ? (4'b0001 << idx) : 4'b0000;
        exp_resp = hit ? R_OKAY : R_DECERR;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = (stall == 0);
        #1;
        n = 0;
        while (!axi.awready && n < 50) begin @(negedge clk); #1; n++; end
        check("aw_accept", 64'(axi.awready && axi.wready), 64'(1));
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
        @(negedge clk);
        check("wr_we", 64'(lbs_we), 64'(hit));
        check("wr_sel", 64'(lbs_sel), 64'(exp_sel));
        if (hit) begin
            check("wr_addr", 64'(lbs_addr), 64'(word));
            check("wr_din_be", {28'd0, lbs_be, lbs_din}, {28'd0, s, d});
        end
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_latency", 64'(n), hit ? 64'(1) : 64'(0));
        check("bresp", 64'(axi.bresp), 64'(exp_resp));
        resp = axi.bresp;
        if (hit) ref_mem[idx][word] = merge(ref_mem[idx][word], d, s);
        if (stall > 0) begin
            ok = 1;
            axi.araddr = 16'h0000; axi.arvalid = 1; axi.awvalid = 1; axi.wvalid = 1;
            repeat (stall) begin
                #1;
                if (!axi.bvalid || axi.bresp !== exp_resp || axi.awready || axi.arready) ok = 0;
                @(negedge clk);
            end
            check("b_stall", 64'(ok), 64'(1));
            axi.arvalid = 0; axi.awvalid = 0; axi.wvalid = 0; axi.bready = 1;
        end
        @(negedge clk);
        check("b_done", 64'(axi.bvalid), 64'(0));
        axi.bready = 0;
    endtask

    task automatic axi_read(input logic [15:0] a, input int stall,
                            output logic [31:0] data, output logic [1:0] resp);
        logic hit, ok;
        logic [1:0] idx, exp_resp;
        logic [9:0] word;
        logic [3:0] exp_sel;
        logic [31:0] exp_data;
        int n;
        hit      = (a[15:14] == 2'b00);
        idx      = a[13:12];
        word     = a[11:2];
        exp_sel  = hit ? (4'b0001 << idx) : 4'b0000;
        exp_resp = hit ? R_OKAY : R_DECERR;
        exp_data = hit ? ref_mem[idx][word] : 32'd0;
        axi.araddr = a; axi.arvalid = 1; axi.rready = (stall == 0);
        #1;
        n = 0;
        while (!axi.arready && n < 50) begin @(negedge clk); #1; n++; end
        check("ar_accept", 64'(axi.arready), 64'(1));
        @(posedge clk); #1;
        axi.arvalid = 0;
        @(negedge clk);
        check("rd_re", 64'(lbs_re), 64'(hit));
        check("rd_sel", 64'(lbs_sel), 64'(exp_sel));
        if (hit) check("rd_addr", 64'(lbs_addr), 64'(word));
        n = 0;
        while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
        check("r_latency", 64'(n), hit ? 64'(RD_LAT + 1) : 64'(0));
        check("rresp", 64'(axi.rresp), 64'(exp_resp));
        check("rdata", 64'(axi.rdata), 64'(exp_data));
        data = axi.rdata;
        resp = axi.rresp;
        if (stall > 0) begin
            ok = 1;
            axi.awaddr = 16'h0000; axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
            repeat (stall) begin
                #1;
                if (!axi.rvalid || axi.rdata !== exp_data || axi.rresp !== exp_resp ||
                    axi.awready || axi.arready) ok = 0;
                @(negedge clk);
            end
            check("r_stall", 64'(ok), 64'(1));
            axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.rready = 1;
        end
        @(negedge clk);
        check("r_done", 64'(axi.rvalid), 64'(0));
        axi.rready = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        bit          chk;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [12];
    logic [1:0]  resp;
    logic [31:0] rdat;
    logic [15:0] ra;
    logic [3:0]  seq;
    int          grants, n;
    logic        both, ok;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h1008, 32'hA5A5_0001, 4'hF, R_OKAY,   1'b0, 32'h0};
        vecs[1]  = '{1'b0, 16'h1008, 32'h0,         4'h0, R_OKAY,   1'b1, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 16'h3004, 32'hDEAD_BEEF, 4'hF, R_OKAY,   1'b0, 32'h0};
        vecs[3]  = '{1'b0, 16'h3004, 32'h0,         4'h0, R_OKAY,   1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 16'h4000, 32'h1234_5678, 4'hF, R_DECERR, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 16'h8000, 32'h0,         4'h0, R_DECERR, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 16'h1009, 32'h1111_2222, 4'h2, R_OKAY,   1'b0, 32'h0};
        vecs[7]  = '{1'b0, 16'h100B, 32'h0,         4'h0, R_OKAY,   1'b1, 32'hA5A5_2201};
        vecs[8]  = '{1'b1, 16'h0FFC, 32'h0000_CAFE, 4'h0, R_OKAY,   1'b0, 32'h0};
        vecs[9]  = '{1'b0, 16'h0FFC, 32'h0,         4'h0, R_OKAY,   1'b1, 32'h5000_03FF};
        vecs[10] = '{1'b1, 16'hC000, 32'h0BAD_0BAD, 4'hF, R_DECERR, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 16'h4FFC, 32'h0,         4'h0, R_DECERR, 1'b1, 32'h0};

        axi.awaddr = '0; axi.wdata = '0; axi.wstrb = '0; axi.araddr = '0;
        do_reset();

        check("reset_ctrl", 64'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                                 lbs_we, lbs_re}), 64'(0));
        check("reset_lbs", 64'({lbs_sel, lbs_addr, lbs_be, lbs_din}), 64'(0));
        check("reset_resp", 64'({axi.rdata, axi.rresp, axi.bresp}), 64'(0));

        // All channels requesting at once: grants must alternate, write first after reset.
        axi.awaddr = 16'h0010; axi.wdata = 32'h7777_0001; axi.wstrb = 4'hF; axi.araddr = 16'h1010;
        axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1; axi.bready = 1; axi.rready = 1;
        n = 0; grants = 0; seq = '0; both = 0;
        while (grants < 4 && n < 100) begin
            #1;
            if (axi.awready && axi.arready) both = 1;
            if (axi.awready || axi.arready) begin
                seq = {seq[2:0], axi.awready};
                grants++;
            end
            if (grants < 4) begin @(negedge clk); n++; end
        end
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
        check("grant_order", 64'(seq), 64'(4'b1010));
        check("grant_exclusive", 64'(both), 64'(0));
        ref_mem[0][4] = 32'h7777_0001;
        repeat (12) @(negedge clk);
        check("arb_drain", 64'({axi.bvalid, axi.rvalid}), 64'(0));
        axi.bready = 0; axi.rready = 0;

        // Address without data, and data without address, must both wait.
        axi.awaddr = 16'h0020; axi.awvalid = 1; ok = 1;
        repeat (5) begin #1; if (axi.awready || axi.wready || lbs_we) ok = 0; @(negedge clk); end
        check("aw_only_wait", 64'(ok), 64'(1));
        axi.awvalid = 0; axi.wvalid = 1; ok = 1;
        repeat (5) begin #1; if (axi.awready || axi.wready || lbs_we) ok = 0; @(negedge clk); end
        check("w_only_wait", 64'(ok), 64'(1));
        axi.wvalid = 0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp);
                check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, 0, rdat, resp);
                check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].resp));
                if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), 64'(rdat), 64'(vecs[i].rdata));
            end
        end

        axi_write(16'h2010, 32'h0BAD_F00D, 4'hF, 10, resp);
        axi_read(16'h2010, 10, rdat, resp);
        check("stall_rdata", 64'(rdat), 64'(32'h0BAD_F00D));

        // Reset while the read is waiting on slave latency.
        axi.araddr = 16'h2008; axi.arvalid = 1; axi.rready = 1;
        @(posedge clk); #1;
        axi.arvalid = 0;
        @(negedge clk);
        @(negedge clk);
        check("rwait_state", 64'({lbs_re, axi.rvalid, lbs_sel}), 64'({1'b0, 1'b0, 4'b0100}));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ctrl", 64'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                                   lbs_we, lbs_re}), 64'(0));
        check("rst_mid_lbs", 64'({lbs_sel, lbs_addr, lbs_be, lbs_din}), 64'(0));
        check("rst_mid_resp", 64'({axi.rdata, axi.rresp, axi.bresp}), 64'(0));
        do_reset();
        axi_read(16'h2008, 0, rdat, resp);
        check("post_reset_read", 64'({rdat, resp}), 64'({init_word(2, 2), R_OKAY}));

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 4) != 0) ra[15:14] = 2'b00;
            else if (ra[15:14] == 2'b00) ra[15] = 1'b1;
            ra[11:2] = 10'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) axi_write(ra, $urandom, 4'($urandom), 0, resp);
            else axi_read(ra, 0, rdat, resp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
